// File: rtl/alu_core.sv
// alu_core: 8-bit ALU with registered result and flags, tri-state bus output.
//   Single-cycle ops (ADD/SUB/AND/OR/XOR/SHL/SHR) complete at the start edge.
//   MUL is an iterative 8-step shift-add with a start/busy/done handshake.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   clr          synchronous clear of result/flags; aborts an operation in progress
//   a_data       operand A
//   b_data       operand B
//   op           operation select, sampled together with start
//   start        begin an operation (accepted only in IDLE)
//   out_en       drive the last completed result onto data
//   data         shared tri-state bus (output only from this block's side)
//   busy         high while not IDLE
//   done         one-cycle pulse after result/flags are written
//   flags        {C, Z, N, V}
module alu_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] a_data,
    input  logic [WIDTH-1:0] b_data,
    input  logic [2:0]       op,
    input  logic             start,
    input  logic             out_en,
    inout  wire  [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic [3:0]       flags
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]   result;
    logic [2*WIDTH-1:0] mcand;     // multiplicand, shifted left each step
    logic [WIDTH-1:0]   mplier;    // multiplier, shifted right each step
    logic [2*WIDTH-1:0] acc;       // partial product
    logic [CW-1:0]      cnt;

    // Single-cycle datapath
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    always_comb begin
        sum     = {1'b0, a_data} + {1'b0, b_data};
        diff    = {1'b0, a_data} - {1'b0, b_data};  // diff[WIDTH] is the borrow
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_data[WIDTH-1] == b_data[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_data[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a_data[WIDTH-1] != b_data[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_data[WIDTH-1]);
            end
            OP_AND: alu_res = a_data & b_data;
            OP_OR:  alu_res = a_data | b_data;
            OP_XOR: alu_res = a_data ^ b_data;
            OP_SHL: begin
                alu_res = {a_data[WIDTH-2:0], 1'b0};
                alu_c   = a_data[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_data[WIDTH-1:1]};
                alu_c   = a_data[0];
            end
            default: ;
        endcase
    end

    // Multiply step: the value the partial product takes after this iteration
    logic [2*WIDTH-1:0] acc_next;
    logic               mul_last;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign mul_last = (cnt == CW'(WIDTH - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // FSM next state; clr wins over everything
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = (op == OP_MUL) ? S_MUL : S_DONE;
            S_MUL:  if (mul_last) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (clr) state_next = S_IDLE;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= '0;
            flags  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (clr) begin
            result <= '0;
            flags  <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    if (op == OP_MUL) begin
                        mcand  <= {{WIDTH{1'b0}}, a_data};
                        mplier <= b_data;
                        acc    <= '0;
                        cnt    <= '0;
                    end else begin
                        result <= alu_res;
                        flags  <= {alu_c, (alu_res == '0), alu_res[WIDTH-1], alu_v};
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (mul_last) begin
                        result <= acc_next[WIDTH-1:0];
                        flags  <= {(acc_next[2*WIDTH-1:WIDTH] != '0),
                                   (acc_next[WIDTH-1:0] == '0),
                                   acc_next[WIDTH-1], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign data = out_en ? result : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [7:0] a_data = '0;
    logic [7:0] b_data = '0;
    logic [2:0] op = '0;
    logic       start = 1'b0;
    logic       out_en = 1'b0;
    wire  [7:0] data;
    logic       busy, done;
    logic [3:0] flags;

    // Bench-side driver on the bus, used to prove the DUT releases it.
    logic       tb_drv = 1'b0;
    logic [7:0] tb_val = '0;
    assign data = tb_drv ? tb_val : 8'bz;

    alu_core #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .clr(clr), .a_data(a_data), .b_data(b_data),
        .op(op), .start(start), .out_en(out_en), .data(data),
        .busy(busy), .done(done), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] flg;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flg;   // {C,Z,N,V}
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", 16'(done), 16'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_result", 16'(data), 16'(e.res));
                chk("sb_flags", 16'(flags), 16'(e.flg));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk("wait_idle", 16'(busy), 16'h0);
    endtask

    // Drive start for exactly one sampling edge; returns just after E0.
    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input bit push, input logic [7:0] r, input logic [3:0] f);
        exp_t e;
        a_data = a;
        b_data = b;
        op     = o;
        start  = 1'b1;
        if (push) begin
            e.res = r;
            e.flg = f;
            sb.push_back(e);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("done_seen", 16'(done), 16'h1);
        tick();
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 4'b0011};
        vecs[1]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 4'b1100};
        vecs[2]  = '{3'b001, 8'h05, 8'h05, 8'h00, 4'b0100};
        vecs[3]  = '{3'b001, 8'h03, 8'h05, 8'hFE, 4'b1010};
        vecs[4]  = '{3'b001, 8'h80, 8'h01, 8'h7F, 4'b0001};
        vecs[5]  = '{3'b010, 8'hF0, 8'h3C, 8'h30, 4'b0000};
        vecs[6]  = '{3'b011, 8'h00, 8'h00, 8'h00, 4'b0100};
        vecs[7]  = '{3'b100, 8'hFF, 8'h0F, 8'hF0, 4'b0010};
        vecs[8]  = '{3'b101, 8'h81, 8'h00, 8'h02, 4'b1000};
        vecs[9]  = '{3'b110, 8'h81, 8'h00, 8'h40, 4'b1000};
        vecs[10] = '{3'b110, 8'h01, 8'h00, 8'h00, 4'b1100};
        vecs[11] = '{3'b111, 8'h0C, 8'h0A, 8'h78, 4'b0000};
        vecs[12] = '{3'b111, 8'h20, 8'h10, 8'h00, 4'b1100};
        vecs[13] = '{3'b111, 8'hFF, 8'hFF, 8'h01, 4'b1000};

        // Reset values
        #4 rst = 1'b0;
        #1;
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_flags", 16'(flags), 16'h0);
        tb_drv = 1'b1; tb_val = 8'hA5;
        #1 chk("rst_bus_released", 16'(data), 16'hA5);
        tb_drv = 1'b0; out_en = 1'b1;
        #1 chk("rst_bus_zero", 16'(data), 16'h00);
        #6 rst = 1'b1;   // t=13, away from the edge at 15
        tick();

        // ADD with done timing and bus release after a nonzero result
        issue(3'b000, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b0011);
        chk("add_done_e0", 16'(done), 16'h1);
        chk("add_busy_e0", 16'(busy), 16'h1);
        tick();
        chk("add_done_e1", 16'(done), 16'h0);
        chk("add_busy_e1", 16'(busy), 16'h0);
        out_en = 1'b0;
        tb_drv = 1'b1; tb_val = 8'h00;
        #1 chk("bus_release_00", 16'(data), 16'h00);
        tb_val = 8'hFF;
        #1 chk("bus_release_ff", 16'(data), 16'hFF);
        tb_drv = 1'b0; out_en = 1'b1;
        #1 chk("result_hold", 16'(data), 16'h80);
        tick(); tick();
        chk("flags_hold", 16'(flags), 16'b0011);

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            wait_idle();
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].res, vecs[i].flg);
            wait_done();
        end

        // MUL latency with operand change during the multiply
        wait_idle();
        issue(3'b111, 8'h0C, 8'h0A, 1'b1, 8'h78, 4'b0000);
        chk("mul_busy_e0", 16'(busy), 16'h1);
        a_data = 8'hFF;
        b_data = 8'hFF;
        begin
            int early = 0;
            for (int k = 1; k <= 8; k++) begin
                if (k < 8 && done) early++;
                if (k < 8) tick();
            end
            chk("mul_no_early_done", 16'(early), 16'h0);
        end
        tick();
        chk("mul_done_e8", 16'(done), 16'h1);
        tick();
        chk("mul_idle_e9", 16'(busy), 16'h0);

        // start (ADD) during MUL is ignored
        issue(3'b111, 8'h03, 8'h05, 1'b1, 8'h0F, 4'b0000);
        tick();
        issue(3'b000, 8'h01, 8'h01, 1'b0, 8'h00, 4'b0000);
        wait_done();
        begin
            int extra = 0;
            for (int k = 0; k < 6; k++) begin
                if (done) extra++;
                tick();
            end
            chk("ignored_start_no_done", 16'(extra), 16'h0);
        end
        chk("ignored_start_result", 16'(data), 16'h0F);

        // clr at iteration 4 of MUL
        wait_idle();
        issue(3'b111, 8'h20, 8'h10, 1'b0, 8'h00, 4'b0000);   // now just after E0
        tick(); tick(); tick();                                // E1..E3
        clr = 1'b1;
        tick();                                                // E4 samples clr
        clr = 1'b0;
        chk("clr_busy", 16'(busy), 16'h0);
        chk("clr_flags", 16'(flags), 16'h0);
        chk("clr_result", 16'(data), 16'h00);
        begin
            int extra = 0;
            for (int k = 0; k < 10; k++) begin
                if (done) extra++;
                tick();
            end
            chk("clr_no_done", 16'(extra), 16'h0);
        end

        // Reset mid-MUL: give a nonzero result first, then abort
        issue(3'b000, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b0011);
        wait_done();
        wait_idle();
        issue(3'b111, 8'hFF, 8'hFF, 1'b0, 8'h00, 4'b0000);
        tick(); tick(); tick();                                // iteration 3 done
        #2 rst = 1'b0;
        #1;
        chk("mrst_busy", 16'(busy), 16'h0);
        chk("mrst_done", 16'(done), 16'h0);
        chk("mrst_flags", 16'(flags), 16'h0);
        chk("mrst_result", 16'(data), 16'h00);
        tick();
        #1 rst = 1'b1;
        begin
            int extra = 0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (done) extra++;
            end
            chk("mrst_no_done", 16'(extra), 16'h0);
        end

        chk("sb_empty", 16'(sb.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
